// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package mc_pkg;

    localparam int unsigned ALU_W   = 2;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_W-1:0] ALU_ORR = 2'b11;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Datapath multiplexer selects produced per FSM state.
    typedef struct packed {
        logic             adr_src;
        logic [SEL_W-1:0] result_src;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
    } dp_sel_t;

endpackage

// File: rtl/mc_decoder_alu_decoder.sv
// ALU operation and flag-write decode from Funct[4:0] when the FSM requests an ALU op.
module alu_decoder
    import mc_pkg::*;
(
    input  logic             alu_op,
    input  logic [4:0]       funct,
    output logic [ALU_W-1:0] alu_control,
    output logic [1:0]       flag_w
);

    logic known;

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        known       = 1'b0;
        if (alu_op) begin
            known = 1'b1;
            case (funct[4:1])
                4'b0100: alu_control = ALU_ADD;
                4'b0010: alu_control = ALU_SUB;
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
                default: begin
                    alu_control = ALU_ADD;
                    known       = 1'b0;
                end
            endcase
            // Unrecognised opcodes execute as ADD but never touch the flags.
            if (known) begin
                flag_w[1] = funct[0];
                flag_w[0] = funct[0] & ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
            end
        end
    end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle ARM control FSM: raw strobes, datapath selects and ALU control.
// Optional retired-instruction counter enabled by defining MC_DEC_PERF_EN.
module mc_decoder
    import mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 2,
    parameter logic [3:0]  RD_PC      = 4'd15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic                  MemReady,
    output logic                  PCS,
    output logic                  RegW,
    output logic                  MemW,
    output logic [1:0]            FlagW,
    output logic                  NextPC,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ResultSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
`ifdef MC_DEC_PERF_EN
    output logic [31:0]           RetireCnt,
`endif
    output logic [ALU_CTRL_W-1:0] ALUControl
);

    state_t           state;
    state_t           state_next;
    dp_sel_t          dp;
    logic             alu_op;
    logic             branch;
    logic             reg_w;
    logic             mem_w;
    logic             next_pc;
    logic             ir_write;
    logic [ALU_W-1:0] alu_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        dp.adr_src    = 1'b0;
        dp.result_src = RES_ALUOUT;
        dp.alu_src_a  = 1'b0;
        dp.alu_src_b  = SRCB_RD2;
        alu_op        = 1'b0;
        branch        = 1'b0;
        reg_w         = 1'b0;
        mem_w         = 1'b0;
        next_pc       = 1'b0;
        ir_write      = 1'b0;
        case (state)
            FETCH: begin
                dp.result_src = RES_ALURESULT;
                dp.alu_src_a  = 1'b1;
                dp.alu_src_b  = SRCB_FOUR;
                // Reset masks the fetch strobes so a held-high MemReady cannot load IR.
                if (MemReady && !reset) begin
                    ir_write   = 1'b1;
                    next_pc    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                dp.result_src = RES_ALURESULT;
                dp.alu_src_a  = 1'b1;
                dp.alu_src_b  = SRCB_FOUR;
                case (Op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                dp.alu_src_b = SRCB_EXTIMM;
                state_next   = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                dp.adr_src = 1'b1;
                if (MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                dp.result_src = RES_DATA;
                reg_w         = 1'b1;
                state_next    = FETCH;
            end
            MEMWRITE: begin
                dp.adr_src = 1'b1;
                mem_w      = 1'b1;
                if (MemReady) state_next = FETCH;
            end
            EXECR: begin
                alu_op     = 1'b1;
                state_next = ALUWB;
            end
            EXECI: begin
                dp.alu_src_b = SRCB_EXTIMM;
                alu_op       = 1'b1;
                state_next   = ALUWB;
            end
            ALUWB: begin
                reg_w      = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                dp.result_src = RES_ALURESULT;
                dp.alu_src_b  = SRCB_EXTIMM;
                branch        = 1'b1;
                state_next    = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct[4:0]),
        .alu_control (alu_ctrl),
        .flag_w      (FlagW)
    );

    assign PCS        = branch | (reg_w & (Rd == RD_PC));
    assign RegW       = reg_w;
    assign MemW       = mem_w;
    assign NextPC     = next_pc;
    assign IRWrite    = ir_write;
    assign AdrSrc     = dp.adr_src;
    assign ResultSrc  = dp.result_src;
    assign ALUSrcA    = dp.alu_src_a;
    assign ALUSrcB    = dp.alu_src_b;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_BR, Op == OP_MEM};
    assign ALUControl = ALU_CTRL_W'(alu_ctrl);

`ifdef MC_DEC_PERF_EN
    logic retire;

    // An instruction retires on the final-state transition back to FETCH.
    assign retire = (state_next == FETCH) &&
                    ((state == MEMWB) || (state == MEMWRITE) || (state == ALUWB) || (state == BRANCH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       RetireCnt <= 32'd0;
        else if (retire) RetireCnt <= RetireCnt + 32'd1;
    end
`endif

endmodule
